des_key_schedule: RTL

Key-schedule datapath of the DES core, directly downstream of the key control unit. It consumes that unit's `load`, `mux`, `shift_1` and `shift_2` strobes and holds the 56-bit C/D state. It emits one 48-bit round subkey per load, with a valid strobe, a round index and a done pulse, to the round-function stage.

---
 rtl/des_key_schedule_pkg.sv | 49 ++++
 rtl/des_key_schedule_if.sv | 25 ++
 rtl/des_key_schedule_pc2.sv | 13 +
 rtl/des_key_schedule.sv | 77 +++++++
 4 files changed

// File: rtl/des_key_schedule_pkg.sv
// Shared constants for the DES key schedule: permutation tables, rotation
// schedule, widths and the 28-bit half-state rotator.
package des_key_schedule_pkg;

    localparam int KEY_W    = 32'sd64;
    localparam int HALF_W   = 32'sd28;
    localparam int STATE_W  = 32'sd56;
    localparam int SUBKEY_W = 32'sd48;

    // Entries are 1-based DES bit numbers, MSB first
    localparam logic [6:0] PC1 [0:55] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2 [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] ROT_SCHED [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [0:27] rotl28(input logic [0:27] v, input logic [1:0] amt);
        logic [0:27] r;
        case (amt)
            2'd0:    r = v;
            2'd1:    r = {v[1:27], v[0]};
            2'd2:    r = {v[2:27], v[0:1]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Strobe/key inputs from the key control unit and subkey outputs to the round stage.
interface des_key_schedule_if;
    import des_key_schedule_pkg::*;

    logic [0:KEY_W-1]    key;
    logic                load;
    logic                mux;
    logic                shift_1;
    logic                shift_2;
    logic [0:SUBKEY_W-1] subkey;
    logic                subkey_valid;
    logic [3:0]          round;
    logic                done;

    modport master (
        output key, load, mux, shift_1, shift_2,
        input  subkey, subkey_valid, round, done
    );

    modport slave (
        input  key, load, mux, shift_1, shift_2,
        output subkey, subkey_valid, round, done
    );

endinterface

// File: rtl/des_key_schedule_pc2.sv
// PC-2 compression permutation of the 56-bit C/D state to a 48-bit subkey; pure wiring.
module des_key_schedule_pc2
    import des_key_schedule_pkg::*;
(
    input  logic [0:STATE_W-1]  cd,
    output logic [0:SUBKEY_W-1] subkey
);

    for (genvar g = 0; g < SUBKEY_W; g++) begin : g_pc2
        assign subkey[g] = cd[PC2[g] - 6'd1];
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES key-schedule datapath: PC-1 load, per-half rotation, C/D and round
// registers, PC-2 subkey output with valid/round/done flags.
module des_key_schedule
    import des_key_schedule_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave ks
);

    logic [0:STATE_W-1]  pc1_s;
    logic [0:HALF_W-1]   src_c_s;
    logic [0:HALF_W-1]   src_d_s;
    logic [0:HALF_W-1]   nxt_c_s;
    logic [0:HALF_W-1]   nxt_d_s;
    logic [1:0]          amt_s;
    logic [3:0]          rnd_nxt_s;
    logic [0:SUBKEY_W-1] subkey_s;

    logic [0:HALF_W-1]   c_r;
    logic [0:HALF_W-1]   d_r;
    logic [3:0]          rnd_r;
    logic                valid_r;
    logic                done_r;

    // Parity bits of the key are simply never selected by PC-1
    for (genvar g = 0; g < STATE_W; g++) begin : g_pc1
        assign pc1_s[g] = ks.key[PC1[g] - 7'd1];
    end

    // Source select, rotate amount and next round index
    always_comb begin
        amt_s = {1'b0, ks.shift_1} + {1'b0, ks.shift_2};
        if (ks.mux) begin
            src_c_s   = c_r;
            src_d_s   = d_r;
            rnd_nxt_s = rnd_r + 4'd1;
        end else begin
            src_c_s   = pc1_s[0:HALF_W-1];
            src_d_s   = pc1_s[HALF_W:STATE_W-1];
            rnd_nxt_s = 4'd0;
        end
        nxt_c_s = rotl28(src_c_s, amt_s);
        nxt_d_s = rotl28(src_d_s, amt_s);
    end

    // C/D state, round counter and output flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_r     <= '0;
            d_r     <= '0;
            rnd_r   <= 4'd0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else if (ks.load) begin
            c_r     <= nxt_c_s;
            d_r     <= nxt_d_s;
            rnd_r   <= rnd_nxt_s;
            valid_r <= 1'b1;
            done_r  <= (rnd_nxt_s == 4'd15);
        end else begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end
    end

    des_key_schedule_pc2 u_pc2 (
        .cd     ({c_r, d_r}),
        .subkey (subkey_s)
    );

    assign ks.subkey       = subkey_s;
    assign ks.subkey_valid = valid_r;
    assign ks.round        = rnd_r;
    assign ks.done         = done_r;

endmodule
